mure_serializer: RTL and testbench

- Drain-side counterpart of the multi-retirement ingress stage.
- Accepts one N-wide retirement bundle, i.e. per-port uop fields plus the common cause/tval/priv fields, over a valid/ready handshake.
- Emits the retired uops one per beat, lowest port index first, to the single-retirement trace encoder interface.
- Slots with iretire=0 are skipped. A bundle with no retired slots is consumed silently.

---
 rtl/mure_pkg.sv | 28 ++
 rtl/mure_lzc_first.sv | 23 ++
 rtl/mure_serializer.sv | 126 ++++++++++++
 tb/tb_mure_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mure_pkg.sv
// Shared widths, payload structs and FSM states for the multi-retirement serializer.
package mure_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned ITYPE_LEN = 3;
    localparam int unsigned CAUSE_LEN = 5;
    localparam int unsigned TVAL_LEN  = 64;
    localparam int unsigned PRIV_LEN  = 2;

    typedef struct packed {
        logic                 iretire;
        logic                 ilastsize;
        logic [ITYPE_LEN-1:0] itype;
        logic [XLEN-1:0]      iaddr;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [TVAL_LEN-1:0]  tval;
        logic [PRIV_LEN-1:0]  priv;
    } common_entry_s;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } ser_state_e;

endpackage

// File: rtl/mure_lzc_first.sv
// Lowest-set-bit finder: index of the least significant 1 plus an all-zero flag.
module mure_lzc_first #(
    parameter int unsigned Width = 2,
    parameter int unsigned IdxW  = 1
) (
    input  logic [Width-1:0] in_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             empty_o
);

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        empty_o = 1'b1;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o   = IdxW'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mure_serializer.sv
// Drains an N-wide retirement bundle into single-retirement beats, lowest port first,
// skipping non-retired slots.
module mure_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [NrRetiredInstr-1:0]                iretire_i,
    input  logic [NrRetiredInstr-1:0]                ilastsize_i,
    input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] itype_i,
    input  logic [NrRetiredInstr-1:0][XLEN-1:0]      iaddr_i,
    input  logic [CAUSE_LEN-1:0]                     cause_i,
    input  logic [TVAL_LEN-1:0]                      tval_i,
    input  logic [PRIV_LEN-1:0]                      priv_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic                                     iretire_o,
    output logic                                     ilastsize_o,
    output logic [ITYPE_LEN-1:0]                     itype_o,
    output logic [XLEN-1:0]                          iaddr_o,
    output logic [CAUSE_LEN-1:0]                     cause_o,
    output logic [TVAL_LEN-1:0]                      tval_o,
    output logic [PRIV_LEN-1:0]                      priv_o,
    output logic                                     busy_o,
    output logic                                     last_o
);

    localparam int unsigned IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

    ser_state_e                      state_q, state_d;
    logic [NrRetiredInstr-1:0]       mask_q, mask_d, mask_clr;
    logic [IdxW-1:0]                 idx_q, idx_d, first_idx, next_idx;
    logic                            first_empty, next_empty;
    uop_entry_s [NrRetiredInstr-1:0] hold_q, hold_d;
    common_entry_s                   common_q, common_d;
    uop_entry_s                      cur;
    logic                            busy, in_xfer;

    assign mask_clr = mask_q & ~(NrRetiredInstr'(1) << idx_q);

    mure_lzc_first #(.Width(NrRetiredInstr), .IdxW(IdxW)) u_lzc_first (
        .in_i    (iretire_i),
        .idx_o   (first_idx),
        .empty_o (first_empty)
    );

    mure_lzc_first #(.Width(NrRetiredInstr), .IdxW(IdxW)) u_lzc_next (
        .in_i    (mask_clr),
        .idx_o   (next_idx),
        .empty_o (next_empty)
    );

    assign busy        = (state_q == DRAIN);
    assign cur         = hold_q[idx_q];
    assign out_valid_o = busy;
    assign busy_o      = busy;
    assign last_o      = busy && next_empty;
    assign in_ready_o  = !busy || (out_ready_i && last_o);
    assign in_xfer     = in_valid_i && in_ready_o;
    assign iretire_o   = busy && cur.iretire;
    assign ilastsize_o = cur.ilastsize;
    assign itype_o     = cur.itype;
    assign iaddr_o     = cur.iaddr;
    assign cause_o     = common_q.cause;
    assign tval_o      = common_q.tval;
    assign priv_o      = common_q.priv;

    // Next-state: advance on an output beat; a new bundle may load in the same cycle as the final beat.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        common_d = common_q;

        unique case (state_q)
            IDLE: ;
            DRAIN: begin
                if (out_ready_i) begin
                    mask_d = mask_clr;
                    idx_d  = next_idx;
                    if (next_empty) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_xfer) begin
            for (int i = 0; i < int'(NrRetiredInstr); i++) begin
                hold_d[i].iretire   = iretire_i[i];
                hold_d[i].ilastsize = ilastsize_i[i];
                hold_d[i].itype     = itype_i[i];
                hold_d[i].iaddr     = iaddr_i[i];
            end
            common_d.cause = cause_i;
            common_d.tval  = tval_i;
            common_d.priv  = priv_i;
            mask_d         = iretire_i;
            idx_d          = first_idx;
            state_d        = first_empty ? IDLE : DRAIN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            common_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            common_q <= common_d;
        end
    end

endmodule

// File: tb/tb_mure_serializer.sv
// Self-checking bench for mure_serializer: directed plan plus random traffic against a beat-queue model.
module tb_mure_serializer;
    import mure_pkg::*;

    localparam int unsigned N = 2;

    logic                        clk_i;
    logic                        rst_ni;
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [N-1:0]                iretire_i;
    logic [N-1:0]                ilastsize_i;
    logic [N-1:0][ITYPE_LEN-1:0] itype_i;
    logic [N-1:0][XLEN-1:0]      iaddr_i;
    logic [CAUSE_LEN-1:0]        cause_i;
    logic [TVAL_LEN-1:0]         tval_i;
    logic [PRIV_LEN-1:0]         priv_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic                        iretire_o;
    logic                        ilastsize_o;
    logic [ITYPE_LEN-1:0]        itype_o;
    logic [XLEN-1:0]             iaddr_o;
    logic [CAUSE_LEN-1:0]        cause_o;
    logic [TVAL_LEN-1:0]         tval_o;
    logic [PRIV_LEN-1:0]         priv_o;
    logic                        busy_o;
    logic                        last_o;

    mure_serializer #(.NrRetiredInstr(N)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .iretire_i   (iretire_i),
        .ilastsize_i (ilastsize_i),
        .itype_i     (itype_i),
        .iaddr_i     (iaddr_i),
        .cause_i     (cause_i),
        .tval_i      (tval_i),
        .priv_i      (priv_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .iretire_o   (iretire_o),
        .ilastsize_o (ilastsize_o),
        .itype_o     (itype_o),
        .iaddr_o     (iaddr_o),
        .cause_o     (cause_o),
        .tval_o      (tval_o),
        .priv_o      (priv_o),
        .busy_o      (busy_o),
        .last_o      (last_o)
    );

    typedef struct {
        logic [XLEN-1:0]      iaddr;
        logic [ITYPE_LEN-1:0] itype;
        logic                 ilastsize;
        logic [CAUSE_LEN-1:0] cause;
        logic [TVAL_LEN-1:0]  tval;
        logic [PRIV_LEN-1:0]  priv;
        logic                 last;
    } beat_t;

    beat_t q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    beat_cnt = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_iretire", 64'(iretire_o), 64'd0);
        chk("rst_ilastsize", 64'(ilastsize_o), 64'd0);
        chk("rst_itype", 64'(itype_o), 64'd0);
        chk("rst_iaddr", iaddr_o, 64'd0);
        chk("rst_cause", 64'(cause_o), 64'd0);
        chk("rst_tval", tval_o, 64'd0);
        chk("rst_priv", 64'(priv_o), 64'd0);
    endtask

    // Every retired slot of an accepted bundle becomes one expected beat, ascending port order.
    task automatic push_bundle();
        beat_t b;
        int    k = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (iretire_i[i]) begin
                b.iaddr     = iaddr_i[i];
                b.itype     = itype_i[i];
                b.ilastsize = ilastsize_i[i];
                b.cause     = cause_i;
                b.tval      = tval_i;
                b.priv      = priv_i;
                b.last      = 1'b0;
                q.push_back(b);
                k++;
            end
        end
        if (k > 0) q[q.size()-1].last = 1'b1;
    endtask

    task automatic cycle(output bit acc);
        bit exp_ready;
        bit exp_valid;
        @(negedge clk_i);
        exp_valid = (q.size() != 0);
        exp_ready = !exp_valid || (q.size() == 1 && out_ready_i);
        chk("in_ready", 64'(in_ready_o), 64'(exp_ready));
        chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
        chk("busy", 64'(busy_o), 64'(exp_valid));
        if (exp_valid) begin
            chk("iretire", 64'(iretire_o), 64'd1);
            chk("iaddr", iaddr_o, q[0].iaddr);
            chk("itype", 64'(itype_o), 64'(q[0].itype));
            chk("ilastsize", 64'(ilastsize_o), 64'(q[0].ilastsize));
            chk("cause", 64'(cause_o), 64'(q[0].cause));
            chk("tval", tval_o, q[0].tval);
            chk("priv", 64'(priv_o), 64'(q[0].priv));
            chk("last", 64'(last_o), 64'(q[0].last));
        end else begin
            chk("idle_last", 64'(last_o), 64'd0);
            chk("idle_iretire", 64'(iretire_o), 64'd0);
        end
        if (out_valid_o === 1'b1 && out_ready_i) beat_cnt++;
        acc = in_valid_i && exp_ready;
        if (exp_valid && out_ready_i) void'(q.pop_front());
        if (acc) push_bundle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step();
        bit a;
        cycle(a);
    endtask

    task automatic set_bundle(input logic [N-1:0] ret, input logic [XLEN-1:0] a0,
                              input logic [XLEN-1:0] a1, input logic [CAUSE_LEN-1:0] c,
                              input logic [PRIV_LEN-1:0] p);
        in_valid_i  = 1'b1;
        iretire_i   = ret;
        iaddr_i[0]  = a0;
        iaddr_i[1]  = a1;
        cause_i     = c;
        priv_i      = p;
        ilastsize_i = N'($urandom);
        for (int i = 0; i < int'(N); i++) itype_i[i] = ITYPE_LEN'($urandom);
        tval_i      = TVAL_LEN'({$urandom, $urandom});
    endtask

    initial begin
        bit acc;
        int sent;
        int beats0;

        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        iretire_i   = '0;
        ilastsize_i = '0;
        itype_i     = '0;
        iaddr_i     = '0;
        cause_i     = '0;
        tval_i      = '0;
        priv_i      = '0;
        #3;
        chk_reset_outputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Two retired slots drain in order with last on the second.
        out_ready_i = 1'b1;
        set_bundle(2'b11, 64'h100, 64'h104, 5'd1, 2'd0);
        step();
        in_valid_i = 1'b0;
        repeat (3) step();

        // Only the upper slot retires.
        set_bundle(2'b10, 64'h0, 64'h200, 5'd5, 2'd3);
        step();
        in_valid_i = 1'b0;
        repeat (2) step();

        // Empty bundle is consumed silently.
        set_bundle(2'b00, 64'h10, 64'h20, 5'd7, 2'd1);
        step();
        in_valid_i = 1'b0;
        repeat (2) step();

        // Output stall holds beat 1 stable.
        set_bundle(2'b11, 64'h100, 64'h104, 5'd2, 2'd1);
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        repeat (3) step();
        out_ready_i = 1'b1;
        repeat (3) step();

        // Three back-to-back bundles: six beats in six consecutive cycles.
        sent   = 0;
        beats0 = beat_cnt;
        for (int c = 0; c < 7; c++) begin
            if (sent < 3) set_bundle(2'b11, XLEN'(64'h300 + 64'(sent) * 64'h10),
                                     XLEN'(64'h304 + 64'(sent) * 64'h10), 5'(sent), 2'(sent));
            else in_valid_i = 1'b0;
            cycle(acc);
            if (acc) sent++;
        end
        in_valid_i = 1'b0;
        chk("stream_sent", 64'(sent), 64'd3);
        chk("stream_beats", 64'(beat_cnt - beats0), 64'd6);
        step();

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) != 0)
                set_bundle(N'($urandom), XLEN'({$urandom, $urandom}), XLEN'({$urandom, $urandom}),
                           CAUSE_LEN'($urandom), PRIV_LEN'($urandom));
            else in_valid_i = 1'b0;
            out_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (4) step();

        // Reset during the first beat aborts the bundle.
        set_bundle(2'b11, 64'h100, 64'h104, 5'd3, 2'd2);
        step();
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        beats0 = beat_cnt;
        repeat (4) step();
        chk("post_reset_beats", 64'(beat_cnt - beats0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
